// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit: decoupled sequential instruction fetch with credit-limited requests and a {PC,instr} FIFO.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counter ports.
module prefetch_fetch_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] program_address,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_target,
    output logic                    mem_req,
    output logic [ADDRESS_BITS-1:0] mem_req_addr,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   instruction,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_stall,
`endif
    output logic [ADDRESS_BITS-1:0] inst_PC
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [ADDRESS_BITS-1:0] fetch_pc, resp_pc, redir_pc;
    logic [CW-1:0] in_flight, in_flight_next, fifo_count, drop_cnt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [ADDRESS_BITS-1:0] pc_q [FIFO_DEPTH];
    logic run, redir, accept, resp, push, pop, fifo_empty;

    // Outstanding requests plus buffered entries never exceed the FIFO depth, so every response has a slot.
    always_comb begin
        run            = state == RUN;
        redir          = start || (run && redirect_valid);
        redir_pc       = (start ? program_address : redirect_target) & ~ADDRESS_BITS'(3);
        fifo_empty     = fifo_count == '0;
        mem_req        = run && !redirect_valid && !start &&
                         (({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
        accept         = mem_req && mem_req_ready;
        resp           = run && mem_resp_valid;
        push           = resp && !redir && drop_cnt == '0;
        inst_valid     = !fifo_empty && !redirect_valid && !start;
        pop            = inst_valid && inst_ready;
        in_flight_next = in_flight + CW'(accept) - CW'(resp);
        state_next     = start ? RUN : state;
        mem_req_addr   = fetch_pc >> 2;
        instruction    = fifo_empty ? '0 : data_q[rd_ptr];
        inst_PC        = fifo_empty ? '0 : pc_q[rd_ptr];
    end

    // resp_pc tracks the PC of the oldest request whose response will be kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= '0;
            resp_pc    <= '0;
            in_flight  <= '0;
            drop_cnt   <= '0;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state     <= state_next;
            in_flight <= in_flight_next;
            if (redir) begin
                fetch_pc   <= redir_pc;
                resp_pc    <= redir_pc;
                drop_cnt   <= in_flight_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + ADDRESS_BITS'(4);
                if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    resp_pc <= resp_pc + ADDRESS_BITS'(4);
                    wr_ptr  <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr] <= mem_resp_data;
            pc_q[wr_ptr]   <= resp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 1'b1;
            if (run && !inst_valid) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// tb_prefetch_fetch_unit: random-latency memory and an epoch-tagged queue model of the fetch stream.
module tb_prefetch_fetch_unit;
    localparam int AB = 20;
    localparam int DW = 32;
    localparam int D  = 4;

    logic clock = 0;
    logic reset, start, redirect_valid, mem_req, mem_req_ready, mem_resp_valid, inst_valid, inst_ready;
    logic [AB-1:0] program_address, redirect_target, mem_req_addr, inst_PC;
    logic [DW-1:0] mem_resp_data, instruction;

    always #5 clock = ~clock;

    prefetch_fetch_unit #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .FIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .start(start), .program_address(program_address),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mem_req(mem_req), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_PC(inst_PC)
    );

    typedef struct {
        logic [AB-1:0] pc;
        logic [AB-1:0] epc;
        int            due;
        int            ep;
    } req_t;

    req_t          mq[$];
    logic [AB-1:0] eq[$];
    logic [AB-1:0] pop_hist[$];
    logic [AB-1:0] npc;
    bit            started;
    int epoch, cyc, vecs, errs, accepts, pops, total_pops;
    int lat_max = 1, resp_pct = 100, rdy_pct = 100, ir_pct = 100;

    function automatic logic [DW-1:0] word(input logic [AB-1:0] pc);
        logic [31:0] w;
        w = 32'(pc >> 2);
        return w * 32'h9E3779B1 + 32'h01234567;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input bit st, input bit rv, input logic [AB-1:0] tgt);
        bit redir, resp, acc;
        req_t r;
        @(negedge clock);
        start           = st;
        redirect_valid  = rv;
        program_address = tgt;
        redirect_target = tgt;
        mem_req_ready   = $urandom_range(99) < rdy_pct;
        inst_ready      = $urandom_range(99) < ir_pct;
        resp            = mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < resp_pct;
        mem_resp_valid  = resp;
        mem_resp_data   = resp ? word(mq[0].pc) : DW'($urandom);
        #1;
        redir = st || (started && rv);
        check("mem_req", 64'(mem_req), 64'(started && !redir && (mq.size() + eq.size() < D)));
        check("inst_valid", 64'(inst_valid), 64'(eq.size() > 0 && !redir));
        if (mem_req) check("mem_req_addr", 64'(mem_req_addr), 64'(npc >> 2));
        if (inst_valid && inst_ready && eq.size() > 0) begin
            check("inst_PC", 64'(inst_PC), 64'(eq[0]));
            check("instruction", 64'(instruction), 64'(word(eq[0])));
            pop_hist.push_back(inst_PC);
            void'(eq.pop_front());
            pops++;
            total_pops++;
        end
        acc = mem_req && mem_req_ready;
        if (resp) begin
            r = mq.pop_front();
            if (!redir && r.ep == epoch) eq.push_back(r.epc);
        end
        if (acc) begin
            r.pc  = mem_req_addr << 2;
            r.epc = npc;
            r.ep  = epoch;
            r.due = cyc + 1 + int'($urandom_range(lat_max - 1));
            if (mq.size() > 0 && r.due < mq[$].due) r.due = mq[$].due;
            mq.push_back(r);
            npc = npc + AB'(4);
            accepts++;
        end
        if (redir) begin
            epoch++;
            eq.delete();
            npc     = tgt & ~AB'(3);
            started = 1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0);
    endtask

    task automatic clear_stats();
        pops    = 0;
        accepts = 0;
        pop_hist.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1;
        start          = 0;
        redirect_valid = 0;
        mem_resp_valid = 0;
        mem_req_ready  = 0;
        inst_ready     = 0;
        @(negedge clock);
        #1;
        check("rst_mem_req", 64'(mem_req), 0);
        check("rst_inst_valid", 64'(inst_valid), 0);
        check("rst_mem_req_addr", 64'(mem_req_addr), 0);
        check("rst_inst_PC", 64'(inst_PC), 0);
        check("rst_instruction", 64'(instruction), 0);
        reset = 0;
        mq.delete();
        eq.delete();
        started = 0;
        npc     = '0;
    endtask

    initial begin
        reset = 1; start = 0; redirect_valid = 0; program_address = '0; redirect_target = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0; inst_ready = 0;
        do_reset();

        // boot at 0x100 with a 1-cycle memory: one instruction per cycle once warmed up
        cycle(1, 0, 20'h100);
        clear_stats();
        idle(4);
        check("t1_first_pc", 64'(pop_hist.size() > 0 ? pop_hist[0] : '1), 64'h100);
        clear_stats();
        idle(10);
        check("t1_rate", 64'(pops), 10);

        // decode stalled: exactly FIFO_DEPTH requests accepted, then resume
        ir_pct = 0;
        cycle(0, 1, 20'h400);
        clear_stats();
        idle(12);
        check("t2_accepts", 64'(accepts), D);
        check("t2_req_stalled", 64'(mem_req), 0);
        ir_pct = 100;
        clear_stats();
        idle(10);
        check("t2_resume", 64'(pops >= 5), 1);

        // three requests in flight, then redirect to 0x200
        rdy_pct = 0;
        idle(10);
        rdy_pct = 100; resp_pct = 0;
        clear_stats();
        idle(3);
        check("t3_inflight", 64'(accepts), 3);
        cycle(0, 1, 20'h200);
        resp_pct = 100;
        clear_stats();
        idle(10);
        check("t3_first_pc", 64'(pop_hist.size() > 0 ? pop_hist[0] : '1), 64'h200);

        // misaligned redirect target is word-aligned
        rdy_pct = 0;
        idle(10);
        rdy_pct = 100;
        cycle(0, 1, 20'h203);
        clear_stats();
        cycle(0, 0, '0);
        check("t4_addr", 64'(mem_req_addr), 64'h80);
        idle(6);
        check("t4_first_pc", 64'(pop_hist.size() > 0 ? pop_hist[0] : '1), 64'h200);

        // start while running at the top of the address space wraps to 0
        cycle(1, 0, 20'hFFFFC);
        clear_stats();
        idle(8);
        check("t5_pc0", 64'(pop_hist.size() > 1 ? pop_hist[0] : '1), 64'hFFFFC);
        check("t5_pc1", 64'(pop_hist.size() > 1 ? pop_hist[1] : '1), 64'h0);

        // reset mid-operation with buffered entries and requests outstanding
        ir_pct = 0; lat_max = 3;
        idle(5);
        do_reset();
        idle(3);

        // randomized operation with redirects and variable latency
        cycle(1, 0, AB'($urandom));
        for (int s = 0; s < 40; s++) begin
            lat_max  = 1 + $urandom_range(5);
            resp_pct = 40 + $urandom_range(60);
            rdy_pct  = 30 + $urandom_range(70);
            ir_pct   = 20 + $urandom_range(80);
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(99) < 2) cycle(1, 0, AB'($urandom));
                else if ($urandom_range(99) < 5) cycle(0, 1, AB'($urandom));
                else cycle(0, 0, '0);
            end
        end
        check("random_progress", 64'(total_pops > 200), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
